// File: rtl/shift_reg_seq_ctrl_if.sv
// Client-side handshake bundle for the shift register sequencing controller.
// The master modport is the client; the slave modport is the controller.
interface shift_reg_seq_ctrl_if #(
  parameter int Width = 8
);
  logic             mode;
  logic             msw_first;
  logic             par_valid;
  logic             par_ready;
  logic             ser_out_valid;
  logic             ser_out_ready;
  logic [Width-1:0] ser_out_word;
  logic             ser_in_valid;
  logic             ser_in_ready;
  logic             par_out_valid;
  logic             par_out_ready;

  modport master (
    output mode, msw_first, par_valid, ser_out_ready, ser_in_valid, par_out_ready,
    input  par_ready, ser_out_valid, ser_out_word, ser_in_ready, par_out_valid
  );

  modport slave (
    input  mode, msw_first, par_valid, ser_out_ready, ser_in_valid, par_out_ready,
    output par_ready, ser_out_valid, ser_out_word, ser_in_ready, par_out_valid
  );
endinterface

// File: rtl/shift_reg_seq_ctrl.sv
// Sequencing controller that runs a parallel-load shift register either as a
// serializer (TX: load frame, drain words) or deserializer (RX: fill, present frame).
module shift_reg_seq_ctrl #(
  parameter int Length = 4,
  parameter int Width  = 8
) (
  input  logic                            clk,
  input  logic                            ares_n,
  input  logic                            sw_clear,
  shift_reg_seq_ctrl_if.slave             bus,
  input  logic [Width-1:0]                sreg_msword,
  input  logic [Width-1:0]                sreg_lsword,
  output logic                            sreg_sres,
  output logic                            sreg_ld_en,
  output logic                            sreg_shift_en,
  output logic                            sreg_msw_first,
  output logic [$clog2(Length+1)-1:0]     word_cnt,
  output logic                            busy
);

  localparam int CNT_W = $clog2(Length + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(Length);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    TX_SHIFT,
    RX_SHIFT,
    RX_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               msw_q, msw_d;
  logic               rst_hold_q;
  logic [CNT_W-1:0]   cnt_inc;

  always_ff @(posedge clk or negedge ares_n) begin
    if (!ares_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      msw_q      <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      msw_q      <= msw_d;
      rst_hold_q <= 1'b0;
    end
  end

  assign cnt_inc = cnt_q + ONE_C;

  // rst_hold_q is treated like sw_clear so nothing handshakes while the register is being cleared.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    msw_d             = msw_q;
    sreg_ld_en        = 1'b0;
    sreg_shift_en     = 1'b0;
    bus.par_ready     = 1'b0;
    bus.ser_out_valid = 1'b0;
    bus.ser_in_ready  = 1'b0;
    bus.par_out_valid = 1'b0;
    if (sw_clear || rst_hold_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.mode) begin
            bus.par_ready = 1'b1;
            if (bus.par_valid) begin
              sreg_ld_en = 1'b1;
              msw_d      = bus.msw_first;
              cnt_d      = LEN_C;
              state_d    = TX_SHIFT;
            end
          end else begin
            bus.ser_in_ready = 1'b1;
            if (bus.ser_in_valid) begin
              sreg_shift_en = 1'b1;
              msw_d         = bus.msw_first;
              cnt_d         = ONE_C;
              state_d       = (Length == 1) ? RX_DONE : RX_SHIFT;
            end
          end
        end
        TX_SHIFT: begin
          bus.ser_out_valid = 1'b1;
          if (bus.ser_out_ready) begin
            sreg_shift_en = 1'b1;
            cnt_d         = cnt_q - ONE_C;
            if (cnt_q == ONE_C) state_d = IDLE;
          end
        end
        RX_SHIFT: begin
          bus.ser_in_ready = 1'b1;
          if (bus.ser_in_valid) begin
            sreg_shift_en = 1'b1;
            cnt_d         = cnt_inc;
            if (cnt_inc == LEN_C) state_d = RX_DONE;
          end
        end
        RX_DONE: begin
          bus.par_out_valid = 1'b1;
          if (bus.par_out_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The register sees the next latch value so the very first RX shift already uses the new order.
  assign sreg_msw_first   = msw_d;
  assign sreg_sres        = sw_clear | rst_hold_q;
  assign bus.ser_out_word = msw_q ? sreg_msword : sreg_lsword;
  assign word_cnt         = cnt_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Bench for shift_reg_seq_ctrl: two controller instances (4x8 and 1x16), each
// driving a behavioural shift register, with a queue scoreboard on output handshakes.
module tb_shift_reg_seq_ctrl;
  localparam int L  = 4;
  localparam int W  = 8;
  localparam int L1 = 1;
  localparam int W1 = 16;

  logic clk, ares_n, sw_clear;

  shift_reg_seq_ctrl_if #(.Width(W))  bus_a();
  shift_reg_seq_ctrl_if #(.Width(W1)) bus_b();

  logic [L*W-1:0] d_a, q_a;
  logic [W-1:0]   win_a;
  logic           sres_a, ld_a, sh_a, mswp_a, busy_a;
  logic [2:0]     cnt_a;

  logic [W1-1:0]  d_b, q_b, win_b;
  logic           sres_b, ld_b, sh_b, mswp_b, busy_b;
  logic [0:0]     cnt_b;

  shift_reg_seq_ctrl #(.Length(L), .Width(W)) dut_a (
    .clk(clk), .ares_n(ares_n), .sw_clear(sw_clear), .bus(bus_a.slave),
    .sreg_msword(q_a[L*W-1 -: W]), .sreg_lsword(q_a[W-1:0]),
    .sreg_sres(sres_a), .sreg_ld_en(ld_a), .sreg_shift_en(sh_a),
    .sreg_msw_first(mswp_a), .word_cnt(cnt_a), .busy(busy_a)
  );

  shift_reg_seq_ctrl #(.Length(L1), .Width(W1)) dut_b (
    .clk(clk), .ares_n(ares_n), .sw_clear(sw_clear), .bus(bus_b.slave),
    .sreg_msword(q_b), .sreg_lsword(q_b),
    .sreg_sres(sres_b), .sreg_ld_en(ld_b), .sreg_shift_en(sh_b),
    .sreg_msw_first(mswp_b), .word_cnt(cnt_b), .busy(busy_b)
  );

  // Behavioural registers: MS-first shifts toward MS (new word enters LS), LS-first the reverse.
  always @(posedge clk) begin
    if (sres_a)     q_a <= '0;
    else if (ld_a)  q_a <= d_a;
    else if (sh_a)  q_a <= mswp_a ? {q_a[L*W-W-1:0], win_a} : {win_a, q_a[L*W-1:W]};
    if (sres_b)     q_b <= '0;
    else if (ld_b)  q_b <= d_b;
    else if (sh_b)  q_b <= win_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   exp_ser_a[$];
  logic [L*W-1:0] exp_par_a[$];
  logic [W1-1:0]  exp_ser_b[$];
  logic [W1-1:0]  exp_par_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation on every completed output handshake.
  always @(negedge clk) begin
    if (ares_n) begin
      if (bus_a.ser_out_valid && bus_a.ser_out_ready) begin
        if (exp_ser_a.size() == 0) chk("ser_a_unexpected_beat", {24'd0, bus_a.ser_out_word}, 32'hFFFF_FFFF);
        else chk("ser_a_word", {24'd0, bus_a.ser_out_word}, {24'd0, exp_ser_a.pop_front()});
      end
      if (bus_a.par_out_valid && bus_a.par_out_ready) begin
        if (exp_par_a.size() == 0) chk("par_a_unexpected_frame", q_a, 32'hFFFF_FFFF);
        else chk("par_a_frame", q_a, exp_par_a.pop_front());
        chk("par_a_cnt", {29'd0, cnt_a}, 32'(L));
      end
      if (bus_b.ser_out_valid && bus_b.ser_out_ready) begin
        if (exp_ser_b.size() == 0) chk("ser_b_unexpected_beat", {16'd0, bus_b.ser_out_word}, 32'hFFFF_FFFF);
        else chk("ser_b_word", {16'd0, bus_b.ser_out_word}, {16'd0, exp_ser_b.pop_front()});
      end
      if (bus_b.par_out_valid && bus_b.par_out_ready) begin
        if (exp_par_b.size() == 0) chk("par_b_unexpected_frame", {16'd0, q_b}, 32'hFFFF_FFFF);
        else chk("par_b_frame", {16'd0, q_b}, {16'd0, exp_par_b.pop_front()});
        chk("par_b_cnt", {31'd0, cnt_b}, 32'(L1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input int max_cycles);
    int n = 0;
    while (busy_a && n < max_cycles) begin
      tick();
      n++;
    end
    chk("a_idle_within_budget", {31'd0, busy_a}, 32'd0);
  endtask

  // Issue one TX frame on instance A; the first n words in travel order are expected.
  task automatic tx_a(input logic [L*W-1:0] d, input logic msw, input int n);
    for (int k = 0; k < n; k++)
      exp_ser_a.push_back(msw ? d[(L-1-k)*W +: W] : d[k*W +: W]);
    d_a             = d;
    bus_a.mode      = 1'b0;
    bus_a.msw_first = msw;
    bus_a.par_valid = 1'b1;
    @(negedge clk);
    chk("tx_par_ready", {31'd0, bus_a.par_ready}, 32'd1);
    chk("tx_ld_en", {31'd0, ld_a}, 32'd1);
    tick();
    bus_a.par_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    ares_n = 1'b1;
    sw_clear = 1'b0;
    bus_a.mode = 1'b0; bus_a.msw_first = 1'b0; bus_a.par_valid = 1'b0;
    bus_a.ser_out_ready = 1'b0; bus_a.ser_in_valid = 1'b0; bus_a.par_out_ready = 1'b0;
    bus_b.mode = 1'b0; bus_b.msw_first = 1'b0; bus_b.par_valid = 1'b0;
    bus_b.ser_out_ready = 1'b0; bus_b.ser_in_valid = 1'b0; bus_b.par_out_ready = 1'b0;
    d_a = '0; win_a = '0; d_b = '0; win_b = '0;

    // Reset and release
    #1 ares_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_par_ready", {31'd0, bus_a.par_ready}, 32'd0);
    chk("rst_valids", {29'd0, bus_a.ser_out_valid, bus_a.ser_in_ready, bus_a.par_out_valid}, 32'd0);
    chk("rst_enables", {30'd0, ld_a, sh_a}, 32'd0);
    chk("rst_word_cnt", {29'd0, cnt_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_sres", {31'd0, sres_a}, 32'd1);
    tick();
    ares_n = 1'b1;
    @(negedge clk);
    chk("post_release_sres_held", {31'd0, sres_a}, 32'd1);
    chk("post_release_par_ready", {31'd0, bus_a.par_ready}, 32'd0);
    tick();
    chk("sres_released", {31'd0, sres_a}, 32'd0);
    chk("idle_par_ready", {31'd0, bus_a.par_ready}, 32'd1);

    // TX MS-first, no stalls
    bus_a.ser_out_ready = 1'b1;
    tx_a(32'hAABBCCDD, 1'b1, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tx_ms_valid", {31'd0, bus_a.ser_out_valid}, 32'd1);
      chk("tx_ms_no_ld", {31'd0, ld_a}, 32'd0);
      tick();
    end
    chk("tx_ms_busy_done", {31'd0, busy_a}, 32'd0);

    // TX LS-first with a 3-cycle stall on the second word
    tx_a(32'hAABBCCDD, 1'b0, 4);
    bus_a.msw_first = 1'b1;
    @(negedge clk);
    chk("tx_ls_cnt_first", {29'd0, cnt_a}, 32'd4);
    tick();
    bus_a.ser_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_word_held", {24'd0, bus_a.ser_out_word}, 32'hCC);
      chk("stall_cnt_held", {29'd0, cnt_a}, 32'd3);
      chk("stall_no_shift", {31'd0, sh_a}, 32'd0);
      chk("stall_order_latched", {31'd0, mswp_a}, 32'd0);
      tick();
    end
    bus_a.ser_out_ready = 1'b1;
    wait_idle_a(10);

    // RX MS-first with gaps between words
    bus_a.mode = 1'b1;
    bus_a.msw_first = 1'b1;
    exp_par_a.push_back(32'h11223344);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < (i % 2) + 1; g++) begin
        bus_a.ser_in_valid = 1'b0;
        @(negedge clk);
        chk("rx_gap_no_shift", {31'd0, sh_a}, 32'd0);
        tick();
      end
      bus_a.ser_in_valid = 1'b1;
      win_a = 8'(8'h11 * (i + 1));
      @(negedge clk);
      chk("rx_ready", {31'd0, bus_a.ser_in_ready}, 32'd1);
      chk("rx_shift", {31'd0, sh_a}, 32'd1);
      tick();
      bus_a.ser_in_valid = 1'b0;
      chk("rx_word_cnt", {29'd0, cnt_a}, 32'(i + 1));
    end
    bus_a.ser_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rx_done_valid_held", {31'd0, bus_a.par_out_valid}, 32'd1);
      chk("rx_done_not_ready", {31'd0, bus_a.ser_in_ready}, 32'd0);
      chk("rx_done_no_shift", {31'd0, sh_a}, 32'd0);
      tick();
    end
    bus_a.ser_in_valid = 1'b0;
    bus_a.par_out_ready = 1'b1;
    tick();
    bus_a.par_out_ready = 1'b0;
    @(negedge clk);
    chk("rx_after_valid", {31'd0, bus_a.par_out_valid}, 32'd0);
    chk("rx_after_cnt", {29'd0, cnt_a}, 32'd0);
    tick();

    // Abort a TX frame after two words, then send a clean frame
    bus_a.ser_out_ready = 1'b1;
    tx_a(32'h01020304, 1'b1, 2);
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    sw_clear = 1'b1;
    @(negedge clk);
    chk("abort_sres", {31'd0, sres_a}, 32'd1);
    chk("abort_no_valid", {31'd0, bus_a.ser_out_valid}, 32'd0);
    chk("abort_no_enables", {30'd0, ld_a, sh_a}, 32'd0);
    tick();
    sw_clear = 1'b0;
    chk("abort_idle", {31'd0, busy_a}, 32'd0);
    chk("abort_cnt", {29'd0, cnt_a}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_stays_quiet", {31'd0, bus_a.ser_out_valid}, 32'd0);
      tick();
    end
    tx_a(32'h55667788, 1'b1, 4);
    wait_idle_a(10);

    // Length=1 instance: one-word RX then one-word TX
    bus_b.mode = 1'b1;
    bus_b.msw_first = 1'b1;
    win_b = 16'hBEEF;
    bus_b.ser_in_valid = 1'b1;
    exp_par_b.push_back(16'hBEEF);
    @(negedge clk);
    chk("b_rx_ready", {31'd0, bus_b.ser_in_ready}, 32'd1);
    chk("b_rx_shift", {31'd0, sh_b}, 32'd1);
    tick();
    bus_b.ser_in_valid = 1'b0;
    chk("b_rx_done_direct", {31'd0, bus_b.par_out_valid}, 32'd1);
    chk("b_rx_cnt", {31'd0, cnt_b}, 32'd1);
    bus_b.par_out_ready = 1'b1;
    tick();
    bus_b.par_out_ready = 1'b0;
    chk("b_rx_back_idle", {31'd0, busy_b}, 32'd0);
    bus_b.mode = 1'b0;
    d_b = 16'h1234;
    exp_ser_b.push_back(16'h1234);
    bus_b.par_valid = 1'b1;
    @(negedge clk);
    chk("b_tx_ld", {31'd0, ld_b}, 32'd1);
    tick();
    bus_b.par_valid = 1'b0;
    bus_b.ser_out_ready = 1'b1;
    @(negedge clk);
    chk("b_tx_cnt", {31'd0, cnt_b}, 32'd1);
    tick();
    chk("b_tx_single_beat", {30'd0, busy_b, bus_b.ser_out_valid}, 32'd0);

    chk("left_ser_a", 32'(exp_ser_a.size()), 32'd0);
    chk("left_par_a", 32'(exp_par_a.size()), 32'd0);
    chk("left_ser_b", 32'(exp_ser_b.size()), 32'd0);
    chk("left_par_b", 32'(exp_par_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
